tl_inflight_monitor: RTL and testbench
======================================

// Module: tl_inflight_monitor
// PURPOSE
// - Parametrised TileLink-UL A/D protocol monitor for testbench use: passive, drives nothing onto the bus.
// - Tracks in-flight requests per source ID and checks each D response against its A request.
// - Checks multi-beat burst stability and a no-progress watchdog; reports a registered error code, source and count.
// - Instantiated beside any TL-UL port in the SoC testbench, generalising the fixed-width per-port monitor wrappers.
// PARAMETERS
// - SOURCE_BITS     4     source ID width; the tracking table has 2**SOURCE_BITS entries
// - SIZE_BITS       4     a_size/d_size width (log2 bytes)
// - ADDR_BITS       30    a_address width
// - BEAT_LOG2       3     log2 of data-bus bytes per beat
// - TIMEOUT_CYCLES  1024  cycles without any D fire while requests are in flight before error 7; 0 disables the watchdog
// PORTS
// - clock           in   1            sole clock
// - reset           in   1            synchronous, active-high
// - a_valid/a_ready in   1/1          A handshake; beat fires when both are 1
// - a_opcode        in   3            0 PutFull, 1 PutPartial, 2 Arith, 3 Logical, 4 Get, 5 Intent
// - a_size          in   SIZE_BITS    log2 transfer bytes
// - a_source        in   SOURCE_BITS  request ID
// - a_address       in   ADDR_BITS    byte address
// - d_valid/d_ready in   1/1          D handshake
// - d_opcode        in   3            0 AccessAck, 1 AccessAckData, 2 HintAck
// - d_size          in   SIZE_BITS    must echo request size
// - d_source        in   SOURCE_BITS  response ID
// - err_valid       out  1            one-cycle pulse, error detected on the previous cycle
// - err_code        out  4            code of the reported error; holds its last value
// - err_source      out  SOURCE_BITS  source of the reported error; holds its last value
// - err_count       out  16           saturating count of error pulses
// - inflight_count  out  SOURCE_BITS+1 number of busy table entries
// BEHAVIOUR
// - Reset: all outputs 0; table busy bits cleared; burst counters and watchdog cleared. Reset mid-burst discards all state.
// - beats(size) = size>BEAT_LOG2 ? 1<<(size-BEAT_LOG2) : 1.
// - A beats = beats(a_size) for Put*/Arith/Logical; 1 for Get/Intent.
// - D beats = beats(d_size) for AccessAckData; 1 otherwise.
// - First A beat allocates the table entry: busy<=1, size and expected D opcode are stored.
//   - Get/Arith/Logical -> 1; Put* -> 0; Intent -> 2.
// - Subsequent A beats do not reallocate the entry.
// - Last D beat clears busy. D last beat and A first beat on the same source in the same cycle are legal: the entry is re-allocated.
// - Same-cycle A allocate and D release on different sources: inflight_count changes by net 0.
// - Errors, checked on fire:
//   - 1 A first beat to a busy source
//   - 2 D to a non-busy source
//   - 3 d_opcode != expected
//   - 4 d_size != stored size
//   - 5 A non-first beat changes opcode/size/source/address
//   - 6 D non-first beat changes opcode/size/source
//   - 7 watchdog expired
//   - 8 a_address not aligned to 2**a_size
// - An erroring D beat still advances the D burst counter and releases the entry on its last beat.
// - An erroring A first beat still allocates the entry.
// - Several errors in one cycle: the lowest code is reported; err_count increments by 1 and saturates at 16'hFFFF.
// - Latency: detection cycle N -> err_valid/err_code/err_source registered at N+1.
// - Watchdog: counter clears on any D fire or when inflight_count==0, otherwise increments. At TIMEOUT_CYCLES it raises error 7 (err_source 0) and clears.
// CONFIGURATION
// - TL_MON_STABLE_CHECK_EN defined: adds error 9. Once a_valid (or d_valid) is 1 with its ready at 0, the next cycle must keep valid at 1 with unchanged payload.
//   - Error 9 takes priority below code 8. err_source is the stalled source.
// - Not defined: no valid/payload hold-stability logic; code 9 is never produced.
// TESTING
// - Get src 3 size 3, then AccessAckData src 3 size 3 -> no err_valid; inflight_count goes 1 then 0.
// - PutFull src 1 size 5 (4 beats, BEAT_LOG2 3), address changes on beat 2 -> err_valid with code 5, src 1 one cycle after beat 2.
// - Get src 2, then second Get src 2 before D -> code 1, src 2; err_count = 1.
// - AccessAck src 7 with nothing in flight -> code 2, src 7. Same cycle as a misaligned A (addr 0x4, size 3) -> code 2 reported, err_count +1.
// - TIMEOUT_CYCLES=16, Get src 0 with no D -> code 7 exactly 16 cycles after the A fire; count resets and code 7 repeats 16 cycles later.
// - TL_MON_STABLE_CHECK_EN: a_valid=1, a_ready=0, then a_valid drops -> code 9. Without the macro -> no error.

Source files
------------

// File: rtl/tl_inflight_monitor.sv
// rtl/tl_inflight_monitor.sv - passive TL-UL A/D in-flight tracker and protocol checker
// Define TL_MON_STABLE_CHECK_EN to add the valid/payload hold-stability check (error 9).
module tl_inflight_monitor #(
  parameter int SOURCE_BITS    = 4,
  parameter int SIZE_BITS      = 4,
  parameter int ADDR_BITS      = 30,
  parameter int BEAT_LOG2      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_a_valid,
  input  logic                   i_a_ready,
  input  logic [2:0]             i_a_opcode,
  input  logic [SIZE_BITS-1:0]   i_a_size,
  input  logic [SOURCE_BITS-1:0] i_a_source,
  input  logic [ADDR_BITS-1:0]   i_a_address,
  input  logic                   i_d_valid,
  input  logic                   i_d_ready,
  input  logic [2:0]             i_d_opcode,
  input  logic [SIZE_BITS-1:0]   i_d_size,
  input  logic [SOURCE_BITS-1:0] i_d_source,
  output logic                   o_err_valid,
  output logic [3:0]             o_err_code,
  output logic [SOURCE_BITS-1:0] o_err_source,
  output logic [15:0]            o_err_count,
  output logic [SOURCE_BITS:0]   o_inflight_count
);
  localparam int ENTRIES = 1 << SOURCE_BITS;
  localparam int CNT_W   = 1 << SIZE_BITS;

  function automatic logic [CNT_W-1:0] f_beats(input logic [SIZE_BITS-1:0] size);
    if (int'(size) > BEAT_LOG2) return CNT_W'(1) << (int'(size) - BEAT_LOG2);
    return CNT_W'(1);
  endfunction

  logic [ENTRIES-1:0]     r_busy, w_busy_next;
  logic [SIZE_BITS-1:0]   r_tbl_size [ENTRIES];
  logic [1:0]             r_tbl_op [ENTRIES];
  logic [CNT_W-1:0]       r_a_left, r_d_left, w_a_beats, w_d_beats;
  logic [2:0]             r_a_op, r_d_op;
  logic [SIZE_BITS-1:0]   r_a_size, r_d_size;
  logic [SOURCE_BITS-1:0] r_a_src, r_d_src, w_d_rel_src, w_src, w_stab_src;
  logic [ADDR_BITS-1:0]   r_a_addr, w_align_mask;
  logic [31:0]            r_wd;
  logic [SOURCE_BITS:0]   w_count_next;
  logic [1:0]             w_a_exp_op;
  logic [3:0]             w_code;
  logic w_a_fire, w_d_fire, w_a_first, w_d_first, w_a_last, w_d_last;
  logic w_a_alloc, w_d_release, w_d_hit, w_wd_run, w_wd_hit, w_stab_err, w_err;
  logic w_e1, w_e2, w_e3, w_e4, w_e5, w_e6, w_e8;

  assign w_a_fire     = i_a_valid & i_a_ready;
  assign w_d_fire     = i_d_valid & i_d_ready;
  assign w_a_beats    = (i_a_opcode <= 3'd3) ? f_beats(i_a_size) : CNT_W'(1);
  assign w_d_beats    = (i_d_opcode == 3'd1) ? f_beats(i_d_size) : CNT_W'(1);
  // r_*_left holds beats still owed after the current one; zero means the next beat is a first beat
  assign w_a_first    = (r_a_left == '0);
  assign w_d_first    = (r_d_left == '0);
  assign w_a_last     = w_a_first ? (w_a_beats == CNT_W'(1)) : (r_a_left == CNT_W'(1));
  assign w_d_last     = w_d_first ? (w_d_beats == CNT_W'(1)) : (r_d_left == CNT_W'(1));
  assign w_a_alloc    = w_a_fire & w_a_first;
  assign w_d_release  = w_d_fire & w_d_last;
  assign w_d_rel_src  = w_d_first ? i_d_source : r_d_src;
  assign w_align_mask = ~({ADDR_BITS{1'b1}} << i_a_size);

  always_comb begin
    case (i_a_opcode)
      3'd0, 3'd1: w_a_exp_op = 2'd0;
      3'd5:       w_a_exp_op = 2'd2;
      default:    w_a_exp_op = 2'd1;
    endcase
  end

  always_comb begin
    w_busy_next = r_busy;
    if (w_d_release) w_busy_next[w_d_rel_src] = 1'b0;
    if (w_a_alloc)   w_busy_next[i_a_source]  = 1'b1;
    w_count_next = '0;
    for (int i = 0; i < ENTRIES; i++)
      w_count_next = w_count_next + (SOURCE_BITS+1)'(w_busy_next[i]);
  end

  assign w_d_hit = r_busy[i_d_source];
  assign w_e1 = w_a_alloc && r_busy[i_a_source] && !(w_d_release && (w_d_rel_src == i_a_source));
  assign w_e2 = w_d_fire && !w_d_hit;
  assign w_e3 = w_d_fire && w_d_hit && (i_d_opcode != {1'b0, r_tbl_op[i_d_source]});
  assign w_e4 = w_d_fire && w_d_hit && (i_d_size != r_tbl_size[i_d_source]);
  assign w_e5 = w_a_fire && !w_a_first && ((i_a_opcode != r_a_op) || (i_a_size != r_a_size) ||
                                           (i_a_source != r_a_src) || (i_a_address != r_a_addr));
  assign w_e6 = w_d_fire && !w_d_first && ((i_d_opcode != r_d_op) || (i_d_size != r_d_size) ||
                                           (i_d_source != r_d_src));
  assign w_e8 = w_a_fire && ((i_a_address & w_align_mask) != '0);

  assign w_wd_run = (TIMEOUT_CYCLES != 0) && !w_d_fire && (o_inflight_count != '0);
  assign w_wd_hit = w_wd_run && (r_wd == 32'(TIMEOUT_CYCLES - 1));

`ifdef TL_MON_STABLE_CHECK_EN
  logic                   r_a_stall, r_d_stall;
  logic [2:0]             r_sa_op, r_sd_op;
  logic [SIZE_BITS-1:0]   r_sa_size, r_sd_size;
  logic [SOURCE_BITS-1:0] r_sa_src, r_sd_src;
  logic [ADDR_BITS-1:0]   r_sa_addr;
  logic                   w_a_unstable, w_d_unstable;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_a_stall <= 1'b0;
      r_d_stall <= 1'b0;
    end else begin
      r_a_stall <= i_a_valid & ~i_a_ready;
      r_d_stall <= i_d_valid & ~i_d_ready;
    end
    r_sa_op   <= i_a_opcode;
    r_sa_size <= i_a_size;
    r_sa_src  <= i_a_source;
    r_sa_addr <= i_a_address;
    r_sd_op   <= i_d_opcode;
    r_sd_size <= i_d_size;
    r_sd_src  <= i_d_source;
  end

  assign w_a_unstable = r_a_stall && (!i_a_valid || (i_a_opcode != r_sa_op) || (i_a_size != r_sa_size) ||
                                      (i_a_source != r_sa_src) || (i_a_address != r_sa_addr));
  assign w_d_unstable = r_d_stall && (!i_d_valid || (i_d_opcode != r_sd_op) || (i_d_size != r_sd_size) ||
                                      (i_d_source != r_sd_src));
  assign w_stab_err   = w_a_unstable | w_d_unstable;
  assign w_stab_src   = w_a_unstable ? r_sa_src : r_sd_src;
`else
  assign w_stab_err = 1'b0;
  assign w_stab_src = '0;
`endif

  always_comb begin
    w_err  = 1'b1;
    w_code = 4'd0;
    w_src  = '0;
    if      (w_e1)       begin w_code = 4'd1; w_src = i_a_source; end
    else if (w_e2)       begin w_code = 4'd2; w_src = i_d_source; end
    else if (w_e3)       begin w_code = 4'd3; w_src = i_d_source; end
    else if (w_e4)       begin w_code = 4'd4; w_src = i_d_source; end
    else if (w_e5)       begin w_code = 4'd5; w_src = i_a_source; end
    else if (w_e6)       begin w_code = 4'd6; w_src = i_d_source; end
    else if (w_wd_hit)   begin w_code = 4'd7; end
    else if (w_e8)       begin w_code = 4'd8; w_src = i_a_source; end
    else if (w_stab_err) begin w_code = 4'd9; w_src = w_stab_src; end
    else                 w_err = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset && w_a_alloc) begin
      r_tbl_size[i_a_source] <= i_a_size;
      r_tbl_op[i_a_source]   <= w_a_exp_op;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_busy           <= '0;
      r_a_left         <= '0;
      r_d_left         <= '0;
      r_a_op           <= '0;
      r_a_size         <= '0;
      r_a_src          <= '0;
      r_a_addr         <= '0;
      r_d_op           <= '0;
      r_d_size         <= '0;
      r_d_src          <= '0;
      r_wd             <= '0;
      o_err_valid      <= 1'b0;
      o_err_code       <= '0;
      o_err_source     <= '0;
      o_err_count      <= '0;
      o_inflight_count <= '0;
    end else begin
      r_busy           <= w_busy_next;
      o_inflight_count <= w_count_next;
      if (w_a_fire) begin
        if (w_a_first) begin
          r_a_left <= w_a_beats - CNT_W'(1);
          r_a_op   <= i_a_opcode;
          r_a_size <= i_a_size;
          r_a_src  <= i_a_source;
          r_a_addr <= i_a_address;
        end else begin
          r_a_left <= r_a_left - CNT_W'(1);
        end
      end
      if (w_d_fire) begin
        if (w_d_first) begin
          r_d_left <= w_d_beats - CNT_W'(1);
          r_d_op   <= i_d_opcode;
          r_d_size <= i_d_size;
          r_d_src  <= i_d_source;
        end else begin
          r_d_left <= r_d_left - CNT_W'(1);
        end
      end
      r_wd        <= (w_wd_run && !w_wd_hit) ? r_wd + 32'd1 : 32'd0;
      o_err_valid <= w_err;
      if (w_err) begin
        o_err_code   <= w_code;
        o_err_source <= w_src;
        if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_tl_inflight_monitor.sv
// tb/tb_tl_inflight_monitor.sv - directed and randomized checks of tl_inflight_monitor
// Error-9 expectations follow TL_MON_STABLE_CHECK_EN.
module tb_tl_inflight_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, d_valid, d_ready;
  logic [2:0]  a_opcode, d_opcode;
  logic [3:0]  a_size, a_source, d_size, d_source;
  logic [29:0] a_address;
  logic        err_valid;
  logic [3:0]  err_code, err_source;
  logic [15:0] err_count;
  logic [4:0]  inflight_count;

  int n_checks = 0;
  int n_errs   = 0;
  int m_errs   = 0;
  int m_inflight = 0;
  int m_op [16];
  int m_size [16];

  tl_inflight_monitor #(
    .SOURCE_BITS(4), .SIZE_BITS(4), .ADDR_BITS(30), .BEAT_LOG2(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_a_valid(a_valid), .i_a_ready(a_ready), .i_a_opcode(a_opcode), .i_a_size(a_size),
    .i_a_source(a_source), .i_a_address(a_address),
    .i_d_valid(d_valid), .i_d_ready(d_ready), .i_d_opcode(d_opcode), .i_d_size(d_size),
    .i_d_source(d_source),
    .o_err_valid(err_valid), .o_err_code(err_code), .o_err_source(err_source),
    .o_err_count(err_count), .o_inflight_count(inflight_count)
  );

  always #5 clk = ~clk;

  function automatic int m_beats(input int size);
    return (size > 3) ? (1 << (size - 3)) : 1;
  endfunction

  function automatic int exp_dop(input int op);
    if (op == 0 || op == 1) return 0;
    if (op == 5) return 2;
    return 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_ready = 1'b1; d_valid = 1'b0; d_ready = 1'b1;
    a_opcode = '0; a_size = '0; a_source = '0; a_address = '0;
    d_opcode = '0; d_size = '0; d_source = '0;
  endtask

  task automatic drive_a(input int op, input int size, input int src, input logic [29:0] addr);
    a_valid = 1'b1; a_ready = 1'b1;
    a_opcode = 3'(op); a_size = 4'(size); a_source = 4'(src); a_address = addr;
  endtask

  task automatic drive_d(input int op, input int size, input int src);
    d_valid = 1'b1; d_ready = 1'b1;
    d_opcode = 3'(op); d_size = 4'(size); d_source = 4'(src);
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; step(); step();
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL reset_valid: got %0d want 0", err_valid); end
    n_checks++; if (err_code !== 4'd0) begin n_errs++; $display("FAIL reset_code: got %0d want 0", err_code); end
    n_checks++; if (err_source !== 4'd0) begin n_errs++; $display("FAIL reset_source: got %0d want 0", err_source); end
    n_checks++; if (err_count !== 16'd0) begin n_errs++; $display("FAIL reset_count: got %0d want 0", err_count); end
    n_checks++; if (inflight_count !== 5'd0) begin n_errs++; $display("FAIL reset_inflight: got %0d want 0", inflight_count); end
    rst = 1'b0; step();
  endtask

  task automatic test_get_ack();
    drive_a(4, 3, 3, 30'h100); step(); idle();
    n_checks++; if (inflight_count !== 5'd1) begin n_errs++; $display("FAIL get_inflight: got %0d want 1", inflight_count); end
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL get_noerr: got %0d want 0", err_valid); end
    drive_d(1, 3, 3); step(); idle();
    n_checks++; if (inflight_count !== 5'd0) begin n_errs++; $display("FAIL ack_inflight: got %0d want 0", inflight_count); end
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL ack_noerr: got %0d want 0", err_valid); end
  endtask

  task automatic test_burst_addr_change();
    for (int b = 0; b < 4; b++) begin
      drive_a(0, 5, 1, (b == 1) ? 30'h48 : 30'h40); step();
      n_checks++; if (err_valid !== (b == 1)) begin n_errs++; $display("FAIL burst_valid beat%0d: got %0d want %0d", b, err_valid, b == 1); end
      if (b == 1) begin
        m_errs++;
        n_checks++; if (err_code !== 4'd5) begin n_errs++; $display("FAIL burst_code: got %0d want 5", err_code); end
        n_checks++; if (err_source !== 4'd1) begin n_errs++; $display("FAIL burst_source: got %0d want 1", err_source); end
      end
    end
    idle(); drive_d(0, 5, 1); step(); idle();
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL burst_ack_valid: got %0d want 0", err_valid); end
    n_checks++; if (inflight_count !== 5'd0) begin n_errs++; $display("FAIL burst_inflight: got %0d want 0", inflight_count); end
    n_checks++; if (err_count !== 16'(m_errs)) begin n_errs++; $display("FAIL burst_count: got %0d want %0d", err_count, m_errs); end
  endtask

  task automatic test_double_get();
    drive_a(4, 2, 2, 30'h10); step();
    drive_a(4, 2, 2, 30'h20); step(); idle();
    m_errs++;
    n_checks++; if (err_valid !== 1'b1) begin n_errs++; $display("FAIL dbl_valid: got %0d want 1", err_valid); end
    n_checks++; if (err_code !== 4'd1) begin n_errs++; $display("FAIL dbl_code: got %0d want 1", err_code); end
    n_checks++; if (err_source !== 4'd2) begin n_errs++; $display("FAIL dbl_source: got %0d want 2", err_source); end
    n_checks++; if (err_count !== 16'(m_errs)) begin n_errs++; $display("FAIL dbl_count: got %0d want %0d", err_count, m_errs); end
    n_checks++; if (inflight_count !== 5'd1) begin n_errs++; $display("FAIL dbl_inflight: got %0d want 1", inflight_count); end
    drive_d(1, 2, 2); step(); idle();
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL dbl_ack_valid: got %0d want 0", err_valid); end
    n_checks++; if (inflight_count !== 5'd0) begin n_errs++; $display("FAIL dbl_ack_inflight: got %0d want 0", inflight_count); end
  endtask

  task automatic test_unexpected_d();
    drive_d(0, 0, 7); step(); idle();
    m_errs++;
    n_checks++; if (err_valid !== 1'b1) begin n_errs++; $display("FAIL ud_valid: got %0d want 1", err_valid); end
    n_checks++; if (err_code !== 4'd2) begin n_errs++; $display("FAIL ud_code: got %0d want 2", err_code); end
    n_checks++; if (err_source !== 4'd7) begin n_errs++; $display("FAIL ud_source: got %0d want 7", err_source); end
    drive_d(0, 0, 7); drive_a(4, 3, 5, 30'h4); step(); idle();
    m_errs++;
    n_checks++; if (err_code !== 4'd2) begin n_errs++; $display("FAIL ud_multi_code: got %0d want 2", err_code); end
    n_checks++; if (err_source !== 4'd7) begin n_errs++; $display("FAIL ud_multi_source: got %0d want 7", err_source); end
    n_checks++; if (err_count !== 16'(m_errs)) begin n_errs++; $display("FAIL ud_multi_count: got %0d want %0d", err_count, m_errs); end
    n_checks++; if (inflight_count !== 5'd1) begin n_errs++; $display("FAIL ud_inflight: got %0d want 1", inflight_count); end
    drive_d(1, 3, 5); step(); idle();
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL ud_ack_valid: got %0d want 0", err_valid); end
    n_checks++; if (inflight_count !== 5'd0) begin n_errs++; $display("FAIL ud_ack_inflight: got %0d want 0", inflight_count); end
  endtask

  task automatic test_back_to_back();
    drive_a(4, 0, 4, 30'h0); step(); idle();
    drive_d(1, 0, 4); drive_a(4, 0, 4, 30'h8); step(); idle();
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL realloc_valid: got %0d want 0", err_valid); end
    n_checks++; if (inflight_count !== 5'd1) begin n_errs++; $display("FAIL realloc_inflight: got %0d want 1", inflight_count); end
    drive_d(1, 0, 4); drive_a(0, 0, 6, 30'h0); step(); idle();
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL swap_valid: got %0d want 0", err_valid); end
    n_checks++; if (inflight_count !== 5'd1) begin n_errs++; $display("FAIL swap_inflight: got %0d want 1", inflight_count); end
    drive_d(0, 0, 6); step(); idle();
    n_checks++; if (inflight_count !== 5'd0) begin n_errs++; $display("FAIL swap_end_inflight: got %0d want 0", inflight_count); end
  endtask

  task automatic test_watchdog();
    int first_hit = -1;
    int second_hit = -1;
    drive_a(4, 0, 0, 30'h0); step(); idle();
    for (int k = 1; k <= 40; k++) begin
      step();
      if (err_valid === 1'b1) begin
        if (first_hit < 0) first_hit = k;
        else if (second_hit < 0) second_hit = k;
        m_errs++;
        n_checks++; if (err_code !== 4'd7 || err_source !== 4'd0) begin n_errs++; $display("FAIL wd_code: got code %0d src %0d want 7/0", err_code, err_source); end
      end
    end
    n_checks++; if (first_hit != 16) begin n_errs++; $display("FAIL wd_first: got cycle %0d want 16", first_hit); end
    n_checks++; if (second_hit != 32) begin n_errs++; $display("FAIL wd_second: got cycle %0d want 32", second_hit); end
    drive_d(1, 0, 0); step(); idle();
    n_checks++; if (inflight_count !== 5'd0) begin n_errs++; $display("FAIL wd_release: got %0d want 0", inflight_count); end
    n_checks++; if (err_count !== 16'(m_errs)) begin n_errs++; $display("FAIL wd_count: got %0d want %0d", err_count, m_errs); end
  endtask

  task automatic test_stable();
    drive_a(4, 0, 9, 30'h0); a_ready = 1'b0; step();
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL stall_valid: got %0d want 0", err_valid); end
    idle(); step();
`ifdef TL_MON_STABLE_CHECK_EN
    m_errs++;
    n_checks++; if (err_valid !== 1'b1) begin n_errs++; $display("FAIL stable_valid: got %0d want 1", err_valid); end
    n_checks++; if (err_code !== 4'd9 || err_source !== 4'd9) begin n_errs++; $display("FAIL stable_code: got code %0d src %0d want 9/9", err_code, err_source); end
`else
    n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL stable_valid: got %0d want 0", err_valid); end
`endif
    n_checks++; if (inflight_count !== 5'd0) begin n_errs++; $display("FAIL stable_inflight: got %0d want 0", inflight_count); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      int srcs[$];
      bit used [16];
      int n, s, idx, nb, dop, send_op;
      logic [29:0] addr;
      bit inject;
      n = $urandom_range(1, 3);
      for (int i = 0; i < 16; i++) used[i] = 1'b0;
      while (srcs.size() < n) begin
        s = $urandom_range(0, 15);
        if (!used[s]) begin used[s] = 1'b1; srcs.push_back(s); end
      end
      foreach (srcs[i]) begin
        s = srcs[i];
        m_op[s] = $urandom_range(0, 5);
        m_size[s] = $urandom_range(0, 5);
        addr = 30'($urandom());
        addr = (addr >> m_size[s]) << m_size[s];
        m_inflight++;
        nb = (m_op[s] <= 3) ? m_beats(m_size[s]) : 1;
        for (int b = 0; b < nb; b++) begin
          drive_a(m_op[s], m_size[s], s, addr); step();
          n_checks++; if (err_valid !== 1'b0) begin n_errs++; $display("FAIL rnd_a_valid r%0d src%0d: got %0d want 0", r, s, err_valid); end
        end
      end
      idle();
      n_checks++; if (inflight_count !== 5'(m_inflight)) begin n_errs++; $display("FAIL rnd_a_inflight r%0d: got %0d want %0d", r, inflight_count, m_inflight); end
      while (srcs.size() > 0) begin
        idx = $urandom_range(0, srcs.size() - 1);
        s = srcs[idx];
        srcs.delete(idx);
        dop = exp_dop(m_op[s]);
        inject = (dop != 1) && ($urandom_range(0, 3) == 0);
        send_op = inject ? ((dop == 0) ? 2 : 0) : dop;
        nb = (dop == 1) ? m_beats(m_size[s]) : 1;
        m_inflight--;
        for (int b = 0; b < nb; b++) begin
          drive_d(send_op, m_size[s], s); step();
          n_checks++; if (err_valid !== inject) begin n_errs++; $display("FAIL rnd_d_valid r%0d src%0d: got %0d want %0d", r, s, err_valid, inject); end
          if (inject) begin
            m_errs++;
            n_checks++; if (err_code !== 4'd3 || err_source !== 4'(s)) begin n_errs++; $display("FAIL rnd_d_code: got code %0d src %0d want 3/%0d", err_code, err_source, s); end
          end
        end
        idle();
      end
      n_checks++; if (inflight_count !== 5'd0) begin n_errs++; $display("FAIL rnd_d_inflight r%0d: got %0d want 0", r, inflight_count); end
    end
    n_checks++; if (err_count !== 16'(m_errs)) begin n_errs++; $display("FAIL rnd_count: got %0d want %0d", err_count, m_errs); end
  endtask

  initial begin
    test_reset();
    test_get_ack();
    test_burst_addr_change();
    test_double_get();
    test_unexpected_d();
    test_back_to_back();
    test_watchdog();
    test_stable();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
